// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider (div_mod_seq).
//   state_t    : controller states (IDLE, RUN, DONE)
//   DIV_WIDTH  : default operand/result width
//   DIV_CNT_W  : width of the iteration counter for DIV_WIDTH
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One radix-2 restoring division step (purely combinational).
//   r       : in  WIDTH+1  current partial remainder
//   q       : in  WIDTH    dividend/quotient shift register
//   d       : in  WIDTH    divisor
//   r_next  : out WIDTH+1  partial remainder after this step
//   q_next  : out WIDTH    shift register after this step (new quotient bit in [0])
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] d_ext;

  // Bring the next dividend bit (MSB of q) into the partial remainder.
  assign r_shift = {r[WIDTH-1:0], q[WIDTH-1]};
  assign d_ext   = {1'b0, d};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    r_next = r_shift;
    q_next = {q[WIDTH-2:0], 1'b0};
    // Restoring step: subtract only when it does not go negative.
    if (r_shift >= d_ext) begin
      r_next = r_shift - d_ext;
      q_next = {q[WIDTH-2:0], 1'b1};
    end
  end

endmodule : div_step

// File: rtl/div_mod_seq.sv
// -----------------------------------------------------------------------------
// div_mod_seq
// Sequential unsigned divider, one quotient bit per clock (restoring).
// Feeds the ALU Division/Modulo channels and the divide-by-zero error.
//   clk         : in   rising-edge clock
//   rst_n       : in   asynchronous active-low reset
//   start       : in   request, accepted in IDLE or DONE
//   dividend    : in   WIDTH unsigned dividend, captured on accept
//   divisor     : in   WIDTH unsigned divisor, captured on accept
//   busy        : out  high while a division is in progress
//   done        : out  one-cycle pulse when results are updated
//   quotient    : out  WIDTH result, held until the next DONE
//   remainder   : out  WIDTH result, held until the next DONE
//   div_by_zero : out  set with done when the divisor was 0
// Nonzero divisor: done WIDTH+1 cycles after start. Zero divisor: 2 cycles.
// -----------------------------------------------------------------------------
module div_mod_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic [CNT_W-1:0] cnt;
  logic             zero_flag;

  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_nxt),
    .q_next (q_nxt)
  );

  // A new request is accepted only when not running; DONE accepts too so
  // back-to-back operations run without an IDLE gap.
  logic accept;
  assign accept = start && (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      zero_flag   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            q_reg     <= dividend;
            d_reg     <= divisor;
            r_reg     <= '0;
            zero_flag <= (divisor == '0);
            cnt       <= (divisor == '0) ? '0 : CNT_W'(WIDTH - 1);
            state     <= RUN;
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          if (zero_flag) begin
            // Divide by zero: skip iterations; q_reg still holds the dividend.
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= q_reg;
            div_by_zero <= 1'b1;
          end else begin
            q_reg <= q_nxt;
            r_reg <= r_nxt;
            if (cnt == '0) begin
              // Last step: publish the step outputs directly.
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= q_nxt;
              remainder   <= r_nxt[WIDTH-1:0];
              div_by_zero <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : div_mod_seq

// File: tb/tb_div_mod_seq.sv
// -----------------------------------------------------------------------------
// tb_div_mod_seq
// Self-checking bench for div_mod_seq. A behavioural model (plain / and %,
// a countdown of remaining busy cycles) predicts busy, done and the held
// results; a negedge process compares them every cycle. Directed operations
// pin the model with hand-computed results and latencies.
// -----------------------------------------------------------------------------
module tb_div_mod_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  div_mod_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_left;   // cycles of busy still to go
  bit           m_done;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  bit           m_z, p_z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_z    <= 1'b0;
      p_q    <= '0;
      p_r    <= '0;
      p_z    <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_q    <= p_q;
          m_r    <= p_r;
          m_z    <= p_z;
        end
      end else if (start) begin
        if (divisor == '0) begin
          p_q    <= '1;
          p_r    <= dividend;
          p_z    <= 1'b1;
          m_left <= 1;
        end else begin
          p_q    <= dividend / divisor;
          p_r    <= dividend % divisor;
          p_z    <= 1'b0;
          m_left <= W;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("busy", 32'(busy), 32'(m_left > 0));
      check("done", 32'(done), 32'(m_done));
      check("quotient", 32'(quotient), 32'(m_q));
      check("remainder", 32'(remainder), 32'(m_r));
      if (m_left == 0) check("div_by_zero", 32'(div_by_zero), 32'(m_z));
    end
  end

  // ---------------- directed helpers ----------------
  // Called just after start is raised (cycle 0). Returns the cycle index at
  // which done is seen, or -1 if it never came. Drops start at drop_at.
  task automatic wait_done(input int drop_at, output int lat);
    lat = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n == drop_at) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input logic [W-1:0] eq, input logic [W-1:0] er, input bit ez);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " quotient"}, 32'(quotient), 32'(eq));
    check({tag, " remainder"}, 32'(remainder), 32'(er));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
  endtask

  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input int exp_lat, input logic [W-1:0] eq, input logic [W-1:0] er,
                    input bit ez);
    int lat;
    @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    wait_done(1, lat);
    check_result(tag, lat, exp_lat, eq, er, ez);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;

    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    op("2047/511", 16'd2047, 16'd511, 17, 16'd4, 16'd3, 1'b0);
    op("FFFF/1", 16'hFFFF, 16'd1, 17, 16'hFFFF, 16'd0, 1'b0);
    op("3/7", 16'd3, 16'd7, 17, 16'd0, 16'd3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold quotient", 32'(quotient), 32'd0);
      check("hold remainder", 32'(remainder), 32'd3);
      check("hold done", 32'(done), 32'd0);
    end
    op("5/0", 16'd5, 16'd0, 2, 16'hFFFF, 16'd5, 1'b1);
    op("10/3", 16'd10, 16'd3, 17, 16'd3, 16'd1, 1'b0);

    // Second start during RUN is ignored.
    @(posedge clk);
    #1;
    start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    lat = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 5) begin start = 1'b1; dividend = 16'd9; divisor = 16'd2; end
      if (n == 6) start = 1'b0;
      if (done) begin lat = n; break; end
    end
    check_result("100/7 ignored", lat, 17, 16'd14, 16'd2, 1'b0);

    // start held through DONE: second op begins with no IDLE gap.
    @(posedge clk);
    #1;
    start = 1'b1; dividend = 16'd1000; divisor = 16'd10;
    lat = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n == 1) begin dividend = 16'd50; divisor = 16'd8; end
      if (done) begin lat = n; break; end
    end
    check_result("1000/10", lat, 17, 16'd100, 16'd0, 1'b0);
    wait_done(0, lat);
    check_result("50/8 b2b", lat, 16, 16'd6, 16'd2, 1'b0);

    // Reset in the middle of RUN aborts the operation.
    @(posedge clk);
    #1;
    start = 1'b1; dividend = 16'd1234; divisor = 16'd5;
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort quotient", 32'(quotient), 32'd0);
    check("abort remainder", 32'(remainder), 32'd0);
    check("abort div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op("255/16", 16'd255, 16'd16, 17, 16'd15, 16'd15, 1'b0);

    // Randomised traffic checked by the per-cycle compare.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      start    = ($urandom_range(0, 2) == 0);
      dividend = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       divisor = '0;
        1, 2:    divisor = 16'($urandom_range(1, 15));
        3:       divisor = dividend;
        default: divisor = 16'($urandom);
      endcase
    end
    start = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_div_mod_seq
